sram_mem_ctrl: RTL

- Memory-stage controller that services the load/store requests of the ARM pipeline.
- Drives a 16-bit asynchronous SRAM with 32-bit word accesses and produces the load word that the MEM/WB pipeline register captures as its memory result.
- Deasserts ready while an access is in flight; the hazard/freeze logic stalls all earlier stages until ready returns.

---
 rtl/sram_mem_ctrl_pkg.sv | 30 +++
 rtl/sram_mem_ctrl_if.sv | 36 +++
 rtl/sram_mem_ctrl_addr_map.sv | 29 ++
 rtl/sram_mem_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sram_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl_pkg
// Purpose  : Shared FSM encodings, SRAM geometry and request record for the
//            memory-stage SRAM controller.
// Revision : 1.0
// ============================================================================
package sram_mem_ctrl_pkg;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_acc_lo = 3'd1;
    localparam logic [2:0] c_st_acc_hi = 3'd2;
    localparam logic [2:0] c_st_wait   = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic [31:0] c_default_base_addr = 32'd1024;

    localparam int c_sram_data_w = 16;
    localparam int c_sram_addr_w = 18;
    localparam int c_word_idx_w  = c_sram_addr_w - 1;

    // Request captured at acceptance; held for the whole access.
    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/sram_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl_if
// Purpose  : Pipeline-side load/store bus between the EXE/MEM register and
//            the SRAM controller.
// Revision : 1.0
// ============================================================================
interface sram_mem_ctrl_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/sram_mem_ctrl_addr_map.sv
`default_nettype none
// ============================================================================
// Module   : sram_addr_map
// Purpose  : Byte address -> SRAM halfword address (rebased, wraps modulo
//            the SRAM size, byte offset dropped).
// Revision : 1.0
// ============================================================================
module sram_addr_map
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = c_default_base_addr
) (
    input  wire [31:0]              address,
    input  wire                     half_sel,
    output logic [c_sram_addr_w-1:0] sram_addr
);

    logic [31:0]             w_off;
    logic [c_word_idx_w-1:0] w_word_idx;
    logic                    w_unused_bits;

    assign w_off         = address - BASE_ADDR;
    assign w_word_idx    = w_off[18:2];
    assign sram_addr     = {w_word_idx, half_sel};
    // Upper offset bits alias onto the same SRAM words by design.
    assign w_unused_bits = ^{w_off[31:19], w_off[1:0]};

endmodule
`default_nettype wire

// File: rtl/sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl
// Purpose  : MEM-stage controller doing 32-bit loads/stores as two halfword
//            cycles on a 16-bit asynchronous SRAM, with a fixed latency.
// Revision : 1.0
// ============================================================================
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = c_default_base_addr,
    parameter int          LATENCY   = 6
) (
    input  wire                      clk,
    input  wire                      rst,
    sram_mem_ctrl_if.slave           bus,
    inout  wire [c_sram_data_w-1:0]  SRAM_DQ,
    output logic [c_sram_addr_w-1:0] SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N
);

    localparam logic [3:0] c_wait_last = 4'(LATENCY - 2);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    req_t        r_req;
    logic [31:0] r_read_data;

    logic                     w_req;
    logic                     w_in_acc;
    logic                     w_hi;
    logic                     w_dq_oe;
    logic [c_sram_data_w-1:0] w_dq_out;
    logic [c_sram_addr_w-1:0] w_map_addr;

    assign w_req    = bus.rd_en | bus.wr_en;
    assign w_hi     = (r_state == c_st_acc_hi);
    assign w_in_acc = (r_state == c_st_acc_lo) || w_hi;
    assign w_dq_oe  = w_in_acc & r_req.is_write;
    assign w_dq_out = w_hi ? r_req.wdata[31:16] : r_req.wdata[15:0];

    sram_addr_map #(
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_map (
        .address   (r_req.addr),
        .half_sel  (w_hi),
        .sram_addr (w_map_addr)
    );

    // All SRAM strobes derive from the registered state, so an async reset
    // releases the bus and write enable in the same instant.
    assign SRAM_ADDR = w_in_acc ? w_map_addr : '0;
    assign SRAM_WE_N = ~w_dq_oe;
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 'z;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign bus.read_data = r_read_data;
    assign bus.ready     = (r_state == c_st_idle) ? ~w_req : (r_state == c_st_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
        end else begin
            if (r_state == c_st_idle) begin
                r_cnt <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_req) begin
                        r_state <= c_st_acc_lo;
                    end
                end
                c_st_acc_lo: begin
                    r_state <= c_st_acc_hi;
                end
                c_st_acc_hi: begin
                    r_state <= (LATENCY == 3) ? c_st_done : c_st_wait;
                end
                c_st_wait: begin
                    if (r_cnt == c_wait_last) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // A simultaneous rd_en/wr_en is a store; inputs are frozen until DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
        end else if ((r_state == c_st_idle) && w_req) begin
            r_req.is_write <= bus.wr_en;
            r_req.addr     <= bus.address;
            r_req.wdata    <= bus.write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= 32'd0;
        end else if (!r_req.is_write) begin
            if (r_state == c_st_acc_lo) begin
                r_read_data[15:0] <= SRAM_DQ;
            end else if (r_state == c_st_acc_hi) begin
                r_read_data[31:16] <= SRAM_DQ;
            end
        end
    end

endmodule
`default_nettype wire
